distance_odometer: RTL and testbench

//   Parametrised successor to the bike-computer distance counter. Counts wheel revolutions from the reed switch.

---
 rtl/distance_odometer.sv | 155 +++++++++++++++
 tb/tb_distance_odometer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/distance_odometer.sv
// ---------------------------------------------------------------------------
// distance_odometer
//   Counts wheel revolutions from a raw reed switch and turns them into
//   distance. Every accepted revolution adds the wheel circumference (cm) to
//   an accumulator. Each time the accumulator passes UNIT_CM, one distance
//   unit is added to the total odometer and to the clearable trip counter.
//   The accumulator keeps the remainder, so no distance is lost at unit
//   boundaries.
//
// Ports
//   clock       in   1       system clock, rising edge
//   reset       in   1       synchronous active-high reset, clears all state
//   reed        in   1       raw asynchronous reed switch (1 = magnet present)
//   circ        in   CIRC_W  wheel circumference in cm, used on revolutions
//   trip_clear  in   1       one-cycle request to zero the trip counter
//   total_dist  out  DIST_W  total distance in units
//   trip_dist   out  DIST_W  trip distance in units
//   unit_tick   out  1       one-cycle pulse per unit boundary crossed
//   rev_tick    out  1       one-cycle pulse per accepted revolution
// ---------------------------------------------------------------------------
module distance_odometer #(
    parameter int CIRC_W   = 8,
    parameter int DIST_W   = 14,
    parameter int UNIT_CM  = 10000,
    parameter int LOCKOUT  = 16,
    parameter int SATURATE = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              reed,
    input  logic [CIRC_W-1:0] circ,
    input  logic              trip_clear,
    output logic [DIST_W-1:0] total_dist,
    output logic [DIST_W-1:0] trip_dist,
    output logic              unit_tick,
    output logic              rev_tick
);

    // Accumulator must hold acc + circ, which stays below 2*UNIT_CM.
    localparam int ACC_W  = $clog2(2 * UNIT_CM);
    // Lockout counter only ever holds LOCKOUT-1 down to 0.
    localparam int LOCK_W = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;

    localparam logic [ACC_W-1:0]  UNIT_VAL  = ACC_W'(UNIT_CM);
    localparam logic [ACC_W-1:0]  ACC_ZERO  = {ACC_W{1'b0}};
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT - 1);
    localparam logic [LOCK_W-1:0] LOCK_ZERO = {LOCK_W{1'b0}};
    localparam logic [LOCK_W-1:0] LOCK_ONE  = LOCK_W'(1'b1);
    localparam logic [DIST_W-1:0] DIST_MAX  = {DIST_W{1'b1}};
    localparam logic [DIST_W-1:0] DIST_ZERO = {DIST_W{1'b0}};
    localparam logic [DIST_W-1:0] DIST_ONE  = DIST_W'(1'b1);

    // Advance a distance counter by one unit, saturating or wrapping at all-ones.
    function automatic logic [DIST_W-1:0] bump(input logic [DIST_W-1:0] cnt,
                                               input logic              inc);
        logic [DIST_W-1:0] nxt;
        if (!inc) begin
            nxt = cnt;
        end else if (cnt == DIST_MAX) begin
            nxt = (SATURATE != 32'sd0) ? DIST_MAX : DIST_ZERO;
        end else begin
            nxt = cnt + DIST_ONE;
        end
        return nxt;
    endfunction

    logic              s1_q, s1_d;
    logic              s2_q, s2_d;
    logic              s3_q, s3_d;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [DIST_W-1:0] total_q, total_d;
    logic [DIST_W-1:0] trip_q, trip_d;
    logic              unit_tick_q, unit_tick_d;
    logic              rev_tick_q, rev_tick_d;

    logic              rev_s;
    logic              unit_inc_s;
    logic [ACC_W-1:0]  sum_s;

    // Next-state logic: synchroniser, lockout, accumulator and distance counters.
    always_comb begin
        s1_d = reed;
        s2_d = s1_q;
        s3_d = s2_q;

        // A rising edge of the synchronised reed counts only outside lockout;
        // edges inside lockout are dropped, never queued.
        rev_s = s2_q & ~s3_q & (lock_cnt_q == LOCK_ZERO);

        sum_s      = acc_q + ACC_W'(circ);
        acc_d      = acc_q;
        unit_inc_s = 1'b0;
        lock_cnt_d = lock_cnt_q;

        if (rev_s) begin
            lock_cnt_d = LOCK_LOAD;
            // UNIT_CM >= max circ, so one revolution crosses at most one unit.
            if (sum_s >= UNIT_VAL) begin
                acc_d      = sum_s - UNIT_VAL;
                unit_inc_s = 1'b1;
            end else begin
                acc_d      = sum_s;
                unit_inc_s = 1'b0;
            end
        end else if (lock_cnt_q != LOCK_ZERO) begin
            lock_cnt_d = lock_cnt_q - LOCK_ONE;
        end else begin
            lock_cnt_d = lock_cnt_q;
        end

        total_d = bump(total_q, unit_inc_s);

        // A clear on the same edge as a unit increment leaves the trip at zero.
        if (trip_clear) begin
            trip_d = DIST_ZERO;
        end else begin
            trip_d = bump(trip_q, unit_inc_s);
        end

        unit_tick_d = unit_inc_s;
        rev_tick_d  = rev_s;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            lock_cnt_q  <= LOCK_ZERO;
            acc_q       <= ACC_ZERO;
            total_q     <= DIST_ZERO;
            trip_q      <= DIST_ZERO;
            unit_tick_q <= 1'b0;
            rev_tick_q  <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            lock_cnt_q  <= lock_cnt_d;
            acc_q       <= acc_d;
            total_q     <= total_d;
            trip_q      <= trip_d;
            unit_tick_q <= unit_tick_d;
            rev_tick_q  <= rev_tick_d;
        end
    end

    assign total_dist = total_q;
    assign trip_dist  = trip_q;
    assign unit_tick  = unit_tick_q;
    assign rev_tick   = rev_tick_q;

endmodule

// File: tb/tb_distance_odometer.sv
// ---------------------------------------------------------------------------
// tb_distance_odometer
//   Three instances share one stimulus: the default configuration plus two
//   small 4-bit configurations (saturating and wrapping). A behavioural model
//   tracks reed edges by cycle distance and distance as plain integer cm/units.
// ---------------------------------------------------------------------------
module tb_distance_odometer;

    localparam int LOCKOUT = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       reed = 1'b0;
    logic [7:0] circ = 8'd0;
    logic       trip_clear = 1'b0;

    logic [13:0] main_total, main_trip;
    logic        main_unit, main_rev;
    logic [3:0]  sat_total, sat_trip, wrp_total, wrp_trip;
    logic        sat_unit, sat_rev, wrp_unit, wrp_rev;

    always #5 clock = ~clock;

    distance_odometer #(.CIRC_W(8), .DIST_W(14), .UNIT_CM(10000), .LOCKOUT(LOCKOUT), .SATURATE(1)) u_main (
        .clock(clock), .reset(reset), .reed(reed), .circ(circ), .trip_clear(trip_clear),
        .total_dist(main_total), .trip_dist(main_trip), .unit_tick(main_unit), .rev_tick(main_rev));

    distance_odometer #(.CIRC_W(8), .DIST_W(4), .UNIT_CM(300), .LOCKOUT(LOCKOUT), .SATURATE(1)) u_sat (
        .clock(clock), .reset(reset), .reed(reed), .circ(circ), .trip_clear(trip_clear),
        .total_dist(sat_total), .trip_dist(sat_trip), .unit_tick(sat_unit), .rev_tick(sat_rev));

    distance_odometer #(.CIRC_W(8), .DIST_W(4), .UNIT_CM(300), .LOCKOUT(LOCKOUT), .SATURATE(0)) u_wrp (
        .clock(clock), .reset(reset), .reed(reed), .circ(circ), .trip_clear(trip_clear),
        .total_dist(wrp_total), .trip_dist(wrp_trip), .unit_tick(wrp_unit), .rev_tick(wrp_rev));

    int n_total = 0;
    int n_bad   = 0;

    // ---------------- behavioural model ----------------
    int ucm [3] = '{10000, 300, 300};
    int wid [3] = '{14, 4, 4};
    int sat [3] = '{1, 1, 0};

    int  m_acc [3] = '{0, 0, 0};
    int  m_tot [3] = '{0, 0, 0};
    int  m_trip[3] = '{0, 0, 0};
    bit  exp_unit[3] = '{1'b0, 1'b0, 1'b0};
    bit  exp_rev = 1'b0;
    int  exp_rev_cnt = 0;
    int  cyc = 0;
    int  last_acc = 0;
    bit  have_acc = 1'b0;
    bit  m_prev = 1'b0;
    bit  pend1 = 1'b0;
    bit  pend2 = 1'b0;

    function automatic int disp(int units, int w, int s);
        int maxv;
        maxv = (1 << w) - 1;
        if (s != 0) return (units > maxv) ? maxv : units;
        return units % (maxv + 1);
    endfunction

    // A reed rise seen at a clock edge counts when at least LOCKOUT edges have
    // passed since the previous counted rise; its effect shows two edges later.
    initial begin
        forever begin
            @(posedge clock);
            cyc = cyc + 1;
            exp_rev = 1'b0;
            for (int i = 0; i < 3; i++) exp_unit[i] = 1'b0;
            if (reset) begin
                m_prev = 1'b0; have_acc = 1'b0; pend1 = 1'b0; pend2 = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    m_acc[i] = 0; m_tot[i] = 0; m_trip[i] = 0;
                end
            end else begin
                if (pend2) begin
                    exp_rev = 1'b1;
                    exp_rev_cnt = exp_rev_cnt + 1;
                    for (int i = 0; i < 3; i++) begin
                        int sum;
                        sum = m_acc[i] + int'(circ);
                        if (sum >= ucm[i]) begin
                            m_acc[i] = sum - ucm[i];
                            m_tot[i] = m_tot[i] + 1;
                            m_trip[i] = m_trip[i] + 1;
                            exp_unit[i] = 1'b1;
                        end else begin
                            m_acc[i] = sum;
                        end
                    end
                end
                if (trip_clear) for (int i = 0; i < 3; i++) m_trip[i] = 0;
                pend2 = pend1;
                pend1 = 1'b0;
                if (reed && !m_prev && (!have_acc || (cyc - last_acc) >= LOCKOUT)) begin
                    pend1 = 1'b1;
                    have_acc = 1'b1;
                    last_acc = cyc;
                end
                m_prev = reed;
            end
        end
    end

    // ---------------- per-cycle observation ----------------
    bit mon_en = 1'b0;
    int cyc_err = 0;
    int obs_rev = 0;
    int obs_unit[3] = '{0, 0, 0};
    int last_unit_rev = 0;

    initial begin
        forever begin
            @(negedge clock);
            if (mon_en) begin
                if (main_rev !== exp_rev || sat_rev !== exp_rev || wrp_rev !== exp_rev) cyc_err = cyc_err + 1;
                if (main_unit !== exp_unit[0] || sat_unit !== exp_unit[1] || wrp_unit !== exp_unit[2]) cyc_err = cyc_err + 1;
                if (main_total !== 14'(disp(m_tot[0], wid[0], sat[0])))  cyc_err = cyc_err + 1;
                if (main_trip  !== 14'(disp(m_trip[0], wid[0], sat[0]))) cyc_err = cyc_err + 1;
                if (sat_total  !== 4'(disp(m_tot[1], wid[1], sat[1])))   cyc_err = cyc_err + 1;
                if (sat_trip   !== 4'(disp(m_trip[1], wid[1], sat[1])))  cyc_err = cyc_err + 1;
                if (wrp_total  !== 4'(disp(m_tot[2], wid[2], sat[2])))   cyc_err = cyc_err + 1;
                if (wrp_trip   !== 4'(disp(m_trip[2], wid[2], sat[2])))  cyc_err = cyc_err + 1;
                if (main_rev === 1'b1) obs_rev = obs_rev + 1;
                if (main_unit === 1'b1) begin
                    obs_unit[0] = obs_unit[0] + 1;
                    last_unit_rev = obs_rev;
                end
                if (sat_unit === 1'b1) obs_unit[1] = obs_unit[1] + 1;
                if (wrp_unit === 1'b1) obs_unit[2] = obs_unit[2] + 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse(input int hi, input int lo);
        reed = 1'b1; tick(hi);
        reed = 1'b0; tick(lo);
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(2);
        reset = 1'b0; tick(1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int b_rev, b_err;
        reed = 1'b1; reset = 1'b1; circ = 8'd200;
        tick(2);
        mon_en = 1'b1;
        #1;
        n_total++; if (main_total !== 14'd0) begin n_bad++; $display("FAIL reset_total: got %0d want 0", main_total); end
        n_total++; if (main_trip !== 14'd0) begin n_bad++; $display("FAIL reset_trip: got %0d want 0", main_trip); end
        n_total++; if (main_rev !== 1'b0 || main_unit !== 1'b0) begin n_bad++; $display("FAIL reset_ticks: got rev=%b unit=%b want 0 0", main_rev, main_unit); end
        n_total++; if (sat_total !== 4'd0 || wrp_total !== 4'd0) begin n_bad++; $display("FAIL reset_small: got %0d/%0d want 0/0", sat_total, wrp_total); end
        b_rev = obs_rev; b_err = cyc_err;
        reset = 1'b0;
        tick(40);
        #1;
        n_total++; if (obs_rev - b_rev !== 1) begin n_bad++; $display("FAIL reset_held_reed_revs: got %0d want 1", obs_rev - b_rev); end
        n_total++; if (cyc_err !== b_err) begin n_bad++; $display("FAIL reset_cycle_model: got %0d mismatching cycles want 0", cyc_err - b_err); end
        reed = 1'b0; tick(20);
    endtask

    task automatic test_clean_pulses();
        int b_rev, b_unit, b_err;
        do_reset();
        circ = 8'd200;
        b_rev = obs_rev; b_unit = obs_unit[0]; b_err = cyc_err;
        repeat (50) pulse(4, 40);
        #1;
        n_total++; if (obs_rev - b_rev !== 50) begin n_bad++; $display("FAIL clean_revs: got %0d want 50", obs_rev - b_rev); end
        n_total++; if (obs_unit[0] - b_unit !== 1) begin n_bad++; $display("FAIL clean_units: got %0d want 1", obs_unit[0] - b_unit); end
        n_total++; if (last_unit_rev - b_rev !== 50) begin n_bad++; $display("FAIL clean_unit_on_rev: got rev %0d want 50", last_unit_rev - b_rev); end
        n_total++; if (main_total !== 14'd1 || main_trip !== 14'd1) begin n_bad++; $display("FAIL clean_dist: got %0d/%0d want 1/1", main_total, main_trip); end
        n_total++; if (cyc_err !== b_err) begin n_bad++; $display("FAIL clean_cycle_model: got %0d mismatching cycles want 0", cyc_err - b_err); end
    endtask

    task automatic test_remainder();
        do_reset();
        circ = 8'd255;
        repeat (40) pulse(2, 16);
        #1;
        n_total++; if (main_total !== 14'd1) begin n_bad++; $display("FAIL rem_40: got %0d want 1", main_total); end
        repeat (39) pulse(2, 16);
        #1;
        n_total++; if (main_total !== 14'd2 || main_trip !== 14'd2) begin n_bad++; $display("FAIL rem_79: got %0d/%0d want 2/2", main_total, main_trip); end
        // remainder 145 needs 38.6 more revs for the next unit
        repeat (38) pulse(2, 16);
        #1;
        n_total++; if (main_total !== 14'd2) begin n_bad++; $display("FAIL rem_117: got %0d want 2", main_total); end
        pulse(2, 16);
        #1;
        n_total++; if (main_total !== 14'd3) begin n_bad++; $display("FAIL rem_118: got %0d want 3", main_total); end
    endtask

    task automatic test_bounce();
        int b_rev, b_err;
        do_reset();
        circ = 8'd10;
        b_rev = obs_rev; b_err = cyc_err;
        for (int j = 0; j < 10; j++) begin reed = (j % 2 == 0); tick(1); end
        reed = 1'b0; tick(6);
        reed = 1'b1; tick(4);        // rise exactly LOCKOUT edges after the first
        reed = 1'b0; tick(30);
        #1;
        n_total++; if (obs_rev - b_rev !== 2) begin n_bad++; $display("FAIL bounce_revs: got %0d want 2", obs_rev - b_rev); end
        b_rev = obs_rev;
        reed = 1'b1; tick(1);
        reed = 1'b0; tick(14);
        reed = 1'b1; tick(20);       // rise one edge too early, then held high
        reed = 1'b0; tick(5);
        reed = 1'b1; tick(3);
        reed = 1'b0; tick(30);
        #1;
        n_total++; if (obs_rev - b_rev !== 2) begin n_bad++; $display("FAIL lockout_edge_revs: got %0d want 2", obs_rev - b_rev); end
        n_total++; if (cyc_err !== b_err) begin n_bad++; $display("FAIL bounce_cycle_model: got %0d mismatching cycles want 0", cyc_err - b_err); end
    endtask

    task automatic test_circ_zero();
        int b_rev, b_unit;
        do_reset();
        circ = 8'd250;
        repeat (39) pulse(2, 16);
        b_rev = obs_rev; b_unit = obs_unit[0];
        circ = 8'd0;
        repeat (10) pulse(2, 16);
        #1;
        n_total++; if (obs_rev - b_rev !== 10) begin n_bad++; $display("FAIL circ0_revs: got %0d want 10", obs_rev - b_rev); end
        n_total++; if (obs_unit[0] !== b_unit || main_total !== 14'd0) begin n_bad++; $display("FAIL circ0_dist: got total %0d want 0", main_total); end
        circ = 8'd250;
        pulse(2, 16);
        #1;
        n_total++; if (main_total !== 14'd1) begin n_bad++; $display("FAIL circ0_remainder_kept: got %0d want 1", main_total); end
    endtask

    task automatic test_trip_clear();
        do_reset();
        circ = 8'd250;
        repeat (200) pulse(2, 16);
        #1;
        n_total++; if (main_total !== 14'd5 || main_trip !== 14'd5) begin n_bad++; $display("FAIL trip_preload: got %0d/%0d want 5/5", main_total, main_trip); end
        repeat (39) pulse(2, 16);
        reed = 1'b1; tick(1);
        reed = 1'b0; tick(1);
        trip_clear = 1'b1; tick(1);  // lands on the unit-crossing edge
        trip_clear = 1'b0;
        #1;
        n_total++; if (main_trip !== 14'd0) begin n_bad++; $display("FAIL trip_clear_wins: got %0d want 0", main_trip); end
        n_total++; if (main_total !== 14'd6) begin n_bad++; $display("FAIL trip_clear_total: got %0d want 6", main_total); end
        n_total++; if (main_unit !== 1'b1) begin n_bad++; $display("FAIL trip_clear_unit_tick: got %b want 1", main_unit); end
        tick(20);
    endtask

    task automatic test_reset_mid();
        int b_rev;
        do_reset();
        circ = 8'd255;
        reed = 1'b1; tick(1);
        reed = 1'b0; tick(4);        // now inside lockout
        reset = 1'b1; tick(1);
        reset = 1'b0;
        #1;
        n_total++; if (main_total !== 14'd0 || main_rev !== 1'b0) begin n_bad++; $display("FAIL midlock_reset: got total %0d rev %b want 0 0", main_total, main_rev); end
        b_rev = obs_rev;
        reed = 1'b1; tick(2);
        reed = 1'b0; tick(20);
        #1;
        n_total++; if (obs_rev - b_rev !== 1) begin n_bad++; $display("FAIL midlock_next_edge: got %0d want 1", obs_rev - b_rev); end
        b_rev = obs_rev;
        reed = 1'b1; tick(1);
        reed = 1'b0; reset = 1'b1; tick(1);
        reset = 1'b0; tick(20);
        #1;
        n_total++; if (obs_rev - b_rev !== 0) begin n_bad++; $display("FAIL midrev_reset_drops: got %0d want 0", obs_rev - b_rev); end
    endtask

    task automatic test_saturate_wrap();
        int b1, b2;
        do_reset();
        circ = 8'd255;
        b1 = obs_unit[1]; b2 = obs_unit[2];
        repeat (20) pulse(2, 16);    // 5100 cm = 17 units of 300 cm
        #1;
        n_total++; if (sat_total !== 4'd15 || sat_trip !== 4'd15) begin n_bad++; $display("FAIL saturate_hold: got %0d/%0d want 15/15", sat_total, sat_trip); end
        n_total++; if (wrp_total !== 4'd1 || wrp_trip !== 4'd1) begin n_bad++; $display("FAIL wrap_around: got %0d/%0d want 1/1", wrp_total, wrp_trip); end
        n_total++; if (obs_unit[1] - b1 !== 17 || obs_unit[2] - b2 !== 17) begin n_bad++; $display("FAIL small_unit_ticks: got %0d/%0d want 17/17", obs_unit[1] - b1, obs_unit[2] - b2); end
        n_total++; if (main_total !== 14'd0) begin n_bad++; $display("FAIL big_unit_untouched: got %0d want 0", main_total); end
    endtask

    task automatic test_random();
        int b_rev, b_exp, b_err;
        do_reset();
        b_rev = obs_rev; b_exp = exp_rev_cnt; b_err = cyc_err;
        for (int k = 0; k < 200; k++) begin
            int hi, lo;
            hi = int'($urandom_range(1, 5));
            lo = int'($urandom_range(1, 30));
            for (int c = 0; c < hi + lo; c++) begin
                reed = (c < hi);
                circ = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
                trip_clear = ($urandom_range(0, 31) == 0);
                tick(1);
            end
        end
        reed = 1'b0; trip_clear = 1'b0; tick(5);
        #1;
        n_total++; if (obs_rev - b_rev !== exp_rev_cnt - b_exp) begin n_bad++; $display("FAIL random_revs: got %0d want %0d", obs_rev - b_rev, exp_rev_cnt - b_exp); end
        n_total++; if (main_total !== 14'(disp(m_tot[0], 14, 1)) || main_trip !== 14'(disp(m_trip[0], 14, 1))) begin n_bad++; $display("FAIL random_main_dist: got %0d/%0d want %0d/%0d", main_total, main_trip, disp(m_tot[0], 14, 1), disp(m_trip[0], 14, 1)); end
        n_total++; if (wrp_total !== 4'(disp(m_tot[2], 4, 0))) begin n_bad++; $display("FAIL random_wrap_total: got %0d want %0d", wrp_total, disp(m_tot[2], 4, 0)); end
        n_total++; if (cyc_err !== b_err) begin n_bad++; $display("FAIL random_cycle_model: got %0d mismatching cycles want 0", cyc_err - b_err); end
    endtask

    initial begin
        test_reset();
        test_clean_pulses();
        test_remainder();
        test_bounce();
        test_circ_zero();
        test_trip_clear();
        test_reset_mid();
        test_saturate_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
